// File: rtl/timer_counter_pkg.sv
// Shared timer/counter definitions: register offsets, FSM encodings, mode codes,
// CTRL layout and the TC0/TC1 address windows used by the CPU and the bridge.
package timer_counter_pkg;

    localparam int unsigned TC_CNT_W  = 32;
    localparam int unsigned TC_CTRL_W = 4;
    localparam int unsigned TC_ADDR_W = 30;
    localparam int unsigned TC_DATA_W = 32;

    // Word offsets within a timer window (byte offset >> 2)
    localparam logic [1:0] TC_OFF_CTRL   = 2'd0;
    localparam logic [1:0] TC_OFF_PRESET = 2'd1;
    localparam logic [1:0] TC_OFF_COUNT  = 2'd2;
    localparam logic [1:0] TC_OFF_RSVD   = 2'd3;

    // MODE field codes; 1x behaves as one-shot
    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_AUTO    = 2'b01;

    // Byte address windows of the two instances
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_END  = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_END  = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // CTRL register layout: [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    // True when a byte address falls in either timer window
    function automatic logic tc_in_window(input logic [31:0] byte_addr);
        return ((byte_addr >= TC0_BASE) && (byte_addr <= TC0_END)) ||
               ((byte_addr >= TC1_BASE) && (byte_addr <= TC1_END));
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a maskable IRQ.
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - synchronous active-low reset
//   addr   - word address; only addr[1:0] is decoded (CTRL, PRESET, COUNT, reserved)
//   we     - word write strobe
//   wdata  - write data
//   rdata  - read data, combinational from addr
//   irq    - interrupt request, CTRL.IM & irq_flag
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned CNT_W = TC_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TC_ADDR_W-1:0] addr,
    input  logic                 we,
    input  logic [TC_DATA_W-1:0] wdata,
    output logic [TC_DATA_W-1:0] rdata,
    output logic                 irq
);

    tc_state_e        state_q, state_d;
    tc_ctrl_t         ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;

    logic wr_ctrl;
    logic wr_preset;
    logic mode_auto;
    logic unused_addr;

    assign wr_ctrl     = we && (addr[1:0] == TC_OFF_CTRL);
    assign wr_preset   = we && (addr[1:0] == TC_OFF_PRESET);
    assign mode_auto   = (ctrl_q.mode == TC_MODE_AUTO);
    assign unused_addr = ^addr[TC_ADDR_W-1:2];

    // Next-state: FSM update first, then CPU writes override CTRL/PRESET/irq_flag
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            TC_IDLE: begin
                if (ctrl_q.en) begin
                    state_d    = TC_LOAD;
                    irq_flag_d = 1'b0;
                end
            end
            TC_LOAD: begin
                count_d = preset_q;
                state_d = TC_CNT;
            end
            TC_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = TC_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // COUNT of 0 or 1 both expire here, so PRESET=0 acts like PRESET=1
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = TC_INT;
                end
            end
            TC_INT: begin
                state_d = TC_IDLE;
                if (mode_auto) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
            default: state_d = TC_IDLE;
        endcase

        if (wr_ctrl) begin
            ctrl_d     = tc_ctrl_t'(wdata[TC_CTRL_W-1:0]);
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = CNT_W'(wdata);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= TC_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Read mux; reserved offset reads zero
    always_comb begin
        rdata = '0;
        case (addr[1:0])
            TC_OFF_CTRL:   rdata = TC_DATA_W'(ctrl_q);
            TC_OFF_PRESET: rdata = TC_DATA_W'(preset_q);
            TC_OFF_COUNT:  rdata = TC_DATA_W'(count_q);
            TC_OFF_RSVD:   rdata = '0;
            default:       rdata = '0;
        endcase
    end

    assign irq = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed testbench for timer_counter: register access, one-shot, auto-reload,
// IRQ masking, mid-count stop/reload, PRESET=0 and synchronous reset.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total;
    int bad;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Write lands on the posedge following the call; returns 1 time unit after it
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        @(negedge clk);
        addr  = {28'd0, off};
        wdata = data;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] off, input logic [31:0] exp, input string tag);
        addr = {28'd0, off};
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int p;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // 1. reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq_during", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk(2'd0, 32'd0, "rst_ctrl");
        rd_chk(2'd1, 32'd0, "rst_preset");
        rd_chk(2'd2, 32'd0, "rst_count");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // 2. one-shot, PRESET=5: irq from edge e0+7, stays high
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        addr = 30'd2;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("os_irq_k%0d", k), {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 7) chk($sformatf("os_cnt_k%0d", k), rdata, 32'(7 - k));
        end
        rd_chk(2'd0, 32'h8, "os_ctrl_en_cleared");
        rd_chk(2'd2, 32'd0, "os_count_zero");

        // 3. auto-reload, PRESET=3: period 6, one-cycle pulse
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        addr = 30'd2;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("ar_irq_k%0d", k), {31'd0, irq},
                (k >= 5 && ((k - 5) % 6) == 0) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                p = (k - 2) % 6;
                exp_cnt = (p < 3) ? (3 - p) : 0;
                chk($sformatf("ar_cnt_k%0d", k), rdata, 32'(exp_cnt));
            end
        end
        rd_chk(2'd0, 32'hB, "ar_ctrl_en_kept");
        wr(2'd0, 32'h0);
        repeat (3) step();

        // 4. IM=0 masks irq; CTRL write clears the latched flag
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk($sformatf("mask_irq_k%0d", k), {31'd0, irq}, 32'd0);
        end
        rd_chk(2'd0, 32'h0, "mask_ctrl_en_cleared");
        wr(2'd0, 32'h8);
        chk("unmask_irq_0", {31'd0, irq}, 32'd0);
        step();
        chk("unmask_irq_1", {31'd0, irq}, 32'd0);

        // PRESET=0 behaves like PRESET=1: irq after edge e0+3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("p0_irq_k%0d", k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
        end

        // 5. clear EN mid-count, then reload
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        addr = 30'd2;
        repeat (5) step();
        chk("stop_cnt_before", rdata, 32'd7);
        wr(2'd0, 32'h0);
        addr = 30'd2;
        #1;
        chk("stop_cnt_edge", rdata, 32'd6);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("stop_cnt_frozen_k%0d", k), rdata, 32'd6);
        end
        wr(2'd0, 32'h9);
        addr = 30'd2;
        step();
        chk("reload_cnt_k1", rdata, 32'd6);
        step();
        chk("reload_cnt_k2", rdata, 32'd10);
        step();
        chk("reload_cnt_k3", rdata, 32'd9);

        // 6. COUNT and reserved offset are read-only; reset mid-count
        wr(2'd2, 32'h1234);
        rd_chk(2'd2, 32'd8, "count_ro");
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk(2'd3, 32'd0, "rsvd_reads_zero");
        rd_chk(2'd1, 32'd10, "preset_before_rst");
        @(negedge clk);
        reset = 1'b0;
        step();
        rd_chk(2'd0, 32'd0, "midrst_ctrl");
        rd_chk(2'd1, 32'd0, "midrst_preset");
        rd_chk(2'd2, 32'd0, "midrst_count");
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
